// File: rtl/ahb_helper_mux.sv
// ahb_helper_mux: grants one AHB master to either the RC4 engine or the
// Edge-Detection engine. The ED engine has two sub-ports: sample-image reads
// (SI) and result writes (ED). The block forwards the owner's request and
// routes completion pulses back to whoever issued the outstanding request.
module ahb_helper_mux #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RC4_start,
    input  logic              ED_start,
    input  logic [DATA_W-1:0] RC4_wdata,
    input  logic [ADDR_W-1:0] RC4_pixNum,
    input  logic [1:0]        RC4_mode,
    input  logic [DATA_W-1:0] ED_wdata,
    input  logic [ADDR_W-1:0] ED_wpixNum,
    input  logic [1:0]        ED_mode,
    input  logic [ADDR_W-1:0] SI_rpixNum,
    input  logic [1:0]        SI_mode,
    input  logic [DATA_W-1:0] rdata,
    input  logic              data_feedback,
    output logic [DATA_W-1:0] RC4_rdata,
    output logic              RC4_dfb,
    output logic              ED_dfb,
    output logic [DATA_W-1:0] SI_rdata,
    output logic              SI_dfb,
    output logic              startAddr_sel,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        size,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] pixNum
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRc4  = 2'd1;
    localparam logic [1:0] StEd   = 2'd2;

    // Which ED sub-port issued the most recent request.
    localparam logic SrcSi = 1'b0;
    localparam logic SrcEd = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              pending_q, pending_d;

    logic [1:0]        req_mode;
    logic [ADDR_W-1:0] req_pix;
    logic [DATA_W-1:0] req_wdata;
    logic              req_sel;
    logic              req_src;
    logic              req_valid;

    // Owner selection: RC4 wins a tie; the bus returns to idle between owners.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (RC4_start) begin
                    state_d = StRc4;
                end else if (ED_start) begin
                    state_d = StEd;
                end
            end
            StRc4:   if (!RC4_start) state_d = StIdle;
            StEd:    if (!ED_start)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pick the raw request of the current owner; SI has priority inside ED.
    always_comb begin
        req_mode  = 2'b00;
        req_pix   = '0;
        req_wdata = '0;
        req_sel   = 1'b0;
        req_src   = SrcSi;
        case (state_q)
            StRc4: begin
                req_mode  = RC4_mode;
                req_pix   = RC4_pixNum;
                req_wdata = RC4_wdata;
                req_sel   = (RC4_mode == 2'b10);
            end
            StEd: begin
                if (SI_mode != 2'b00) begin
                    req_mode = SI_mode;
                    req_pix  = SI_rpixNum;
                    req_src  = SrcSi;
                end else if (ED_mode != 2'b00) begin
                    req_mode  = ED_mode;
                    req_pix   = ED_wpixNum;
                    req_wdata = ED_wdata;
                    req_sel   = 1'b1;
                    req_src   = SrcEd;
                end
            end
            default: ;
        endcase
    end

    // Only read (01) and write (10) reach the master; 11 is squashed to none.
    always_comb begin
        req_valid     = (req_mode == 2'b01) || (req_mode == 2'b10);
        mode          = req_valid ? req_mode : 2'b00;
        size          = req_valid ? 2'b10 : 2'b00;
        pixNum        = req_pix;
        wdata         = req_wdata;
        startAddr_sel = req_sel;
    end

    // Remember the requesting ED sub-port so late feedback is routed correctly.
    always_comb begin
        pending_d = pending_q;
        if (state_q == StEd && req_valid) begin
            pending_d = req_src;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= SrcSi;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Response routing: read data is broadcast, completions are gated by owner.
    always_comb begin
        RC4_rdata = rdata;
        SI_rdata  = rdata;
        RC4_dfb   = data_feedback && (state_q == StRc4);
        ED_dfb    = data_feedback && (state_q == StEd);
        SI_dfb    = data_feedback && (state_q == StEd) && (pending_q == SrcSi);
    end

endmodule

// File: tb/tb_ahb_helper_mux.sv
// Bench for ahb_helper_mux: expectations are queued when stimulus is applied
// and popped/compared on the falling clock edge.
module tb_ahb_helper_mux;

    logic        tb_clk;
    logic        rst;
    logic        RC4_start, ED_start;
    logic [31:0] RC4_wdata, ED_wdata, rdata;
    logic [19:0] RC4_pixNum, ED_wpixNum, SI_rpixNum;
    logic [1:0]  RC4_mode, ED_mode, SI_mode;
    logic        data_feedback;
    logic [31:0] RC4_rdata, SI_rdata, wdata;
    logic        RC4_dfb, ED_dfb, SI_dfb, startAddr_sel;
    logic [1:0]  size, mode;
    logic [19:0] pixNum;

    typedef struct packed {
        logic [1:0]  mode;
        logic [1:0]  size;
        logic [19:0] pix;
        logic [31:0] wdata;
        logic        sel;
        logic        rc4_dfb;
        logic        ed_dfb;
        logic        si_dfb;
        logic [31:0] rd;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    ahb_helper_mux #(.ADDR_W(20), .DATA_W(32)) dut (
        .clk           (tb_clk),
        .rst           (rst),
        .RC4_start     (RC4_start),
        .ED_start      (ED_start),
        .RC4_wdata     (RC4_wdata),
        .RC4_pixNum    (RC4_pixNum),
        .RC4_mode      (RC4_mode),
        .ED_wdata      (ED_wdata),
        .ED_wpixNum    (ED_wpixNum),
        .ED_mode       (ED_mode),
        .SI_rpixNum    (SI_rpixNum),
        .SI_mode       (SI_mode),
        .rdata         (rdata),
        .data_feedback (data_feedback),
        .RC4_rdata     (RC4_rdata),
        .RC4_dfb       (RC4_dfb),
        .ED_dfb        (ED_dfb),
        .SI_rdata      (SI_rdata),
        .SI_dfb        (SI_dfb),
        .startAddr_sel (startAddr_sel),
        .wdata         (wdata),
        .size          (size),
        .mode          (mode),
        .pixNum        (pixNum)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    // Queue the outputs required in the current cycle; rdata echoes what was driven.
    task automatic expect_out(input string tag, input logic [1:0] m, input logic [1:0] sz,
                              input logic [19:0] p, input logic [31:0] w, input logic sel,
                              input logic r4, input logic ed, input logic si);
        exp_t e;
        e.mode    = m;
        e.size    = sz;
        e.pix     = p;
        e.wdata   = w;
        e.sel     = sel;
        e.rc4_dfb = r4;
        e.ed_dfb  = ed;
        e.si_dfb  = si;
        e.rd      = rdata;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic expect_idle(input string tag, input logic r4, input logic ed, input logic si);
        expect_out(tag, 2'b00, 2'b00, 20'd0, 32'd0, 1'b0, r4, ed, si);
    endtask

    // Scoreboard consumer: compare every queued expectation mid-cycle.
    always @(negedge tb_clk) begin
        while (exp_q.size() != 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".mode"},      {30'd0, mode},          {30'd0, e.mode});
            check({t, ".size"},      {30'd0, size},          {30'd0, e.size});
            check({t, ".pixNum"},    {12'd0, pixNum},        {12'd0, e.pix});
            check({t, ".wdata"},     wdata,                  e.wdata);
            check({t, ".sel"},       {31'd0, startAddr_sel}, {31'd0, e.sel});
            check({t, ".RC4_dfb"},   {31'd0, RC4_dfb},       {31'd0, e.rc4_dfb});
            check({t, ".ED_dfb"},    {31'd0, ED_dfb},        {31'd0, e.ed_dfb});
            check({t, ".SI_dfb"},    {31'd0, SI_dfb},        {31'd0, e.si_dfb});
            check({t, ".RC4_rdata"}, RC4_rdata,              e.rd);
            check({t, ".SI_rdata"},  SI_rdata,               e.rd);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [19:0] fill_pix [2];
    logic [31:0] fill_dat [2];

    initial begin
        rst = 1'b1;
        RC4_start = 1'b0; ED_start = 1'b0;
        RC4_wdata = '0; ED_wdata = '0; rdata = '0;
        RC4_pixNum = '0; ED_wpixNum = '0; SI_rpixNum = '0;
        RC4_mode = '0; ED_mode = '0; SI_mode = '0;
        data_feedback = 1'b0;
        fill_pix[0] = 20'd481; fill_dat[0] = 32'd255;
        fill_pix[1] = 20'd961; fill_dat[1] = 32'd512;

        cyc(); cyc();
        rst = 1'b0;

        // Idle: feedback is ignored and nothing is driven.
        rdata = 32'h77; data_feedback = 1'b1;
        expect_idle("idle_fb", 0, 0, 0);
        cyc(); data_feedback = 1'b0;
        expect_idle("idle", 0, 0, 0);
        cyc();

        // ED grant takes effect at the next edge; SI read wins over ED request.
        ED_start = 1'b1; ED_mode = 2'b01; SI_mode = 2'b01; SI_rpixNum = 20'd1;
        expect_idle("ed_pre", 0, 0, 0);
        cyc();
        expect_out("si_rd", 2'b01, 2'b10, 20'd1, 32'd0, 1'b0, 0, 0, 0);
        cyc();
        expect_out("si_rd_hold", 2'b01, 2'b10, 20'd1, 32'd0, 1'b0, 0, 0, 0);
        cyc();
        SI_mode = 2'b00; ED_mode = 2'b00; rdata = 32'd1; data_feedback = 1'b1;
        expect_idle("si_fb", 0, 1, 1);
        cyc(); data_feedback = 1'b0;
        expect_idle("si_fb_off", 0, 0, 0);

        // Buffer fill: two SI reads, each completed after the request drops.
        for (int i = 0; i < 2; i++) begin
            cyc();
            SI_mode = 2'b01; SI_rpixNum = fill_pix[i]; rdata = fill_dat[i];
            expect_out("fill_req", 2'b01, 2'b10, fill_pix[i], 32'd0, 1'b0, 0, 0, 0);
            cyc();
            SI_mode = 2'b00; data_feedback = 1'b1;
            expect_idle("fill_fb", 0, 1, 1);
            cyc(); data_feedback = 1'b0;
            expect_idle("fill_off", 0, 0, 0);
        end

        // ED result write: destination region, SI completion must stay low.
        cyc();
        ED_mode = 2'b10; ED_wpixNum = 20'd5; ED_wdata = 32'hA5;
        expect_out("ed_wr", 2'b10, 2'b10, 20'd5, 32'hA5, 1'b1, 0, 0, 0);
        cyc();
        ED_mode = 2'b00; data_feedback = 1'b1;
        expect_idle("ed_wr_fb", 0, 1, 0);
        cyc(); data_feedback = 1'b0;

        // Both ED sub-ports request: SI takes the bus.
        SI_mode = 2'b10; ED_mode = 2'b10; SI_rpixNum = 20'd7;
        expect_out("prio", 2'b10, 2'b10, 20'd7, 32'd0, 1'b0, 0, 0, 0);
        cyc();
        SI_mode = 2'b00; ED_mode = 2'b00; ED_start = 1'b0; data_feedback = 1'b1;
        expect_idle("ed_drop_pre", 0, 1, 1);
        cyc();
        expect_idle("ed_drop", 0, 0, 0);
        cyc();

        // Arbitration: both request from idle, RC4 wins.
        data_feedback = 1'b0; RC4_start = 1'b1; ED_start = 1'b1;
        RC4_mode = 2'b10; RC4_pixNum = 20'd9; RC4_wdata = 32'h1234;
        expect_idle("arb_pre", 0, 0, 0);
        cyc(); data_feedback = 1'b1; rdata = 32'hDEAD_BEEF;
        expect_out("arb_rc4", 2'b10, 2'b10, 20'd9, 32'h1234, 1'b1, 1, 0, 0);
        cyc(); data_feedback = 1'b0; RC4_mode = 2'b01;
        expect_out("rc4_rd", 2'b01, 2'b10, 20'd9, 32'h1234, 1'b0, 0, 0, 0);
        cyc(); RC4_mode = 2'b11;
        expect_out("rc4_m11", 2'b00, 2'b00, 20'd9, 32'h1234, 1'b0, 0, 0, 0);
        cyc(); RC4_mode = 2'b00; RC4_start = 1'b0;
        expect_out("rc4_drop_pre", 2'b00, 2'b00, 20'd9, 32'h1234, 1'b0, 0, 0, 0);
        cyc();
        expect_idle("rc4_idle", 0, 0, 0);
        cyc();
        ED_mode = 2'b10; ED_wpixNum = 20'd5; ED_wdata = 32'hA5;
        expect_out("ed_after", 2'b10, 2'b10, 20'd5, 32'hA5, 1'b1, 0, 0, 0);

        // Reset mid-ED: idle right after the edge, and the SI route is restored.
        cyc(); rst = 1'b1;
        expect_out("rst_pre", 2'b10, 2'b10, 20'd5, 32'hA5, 1'b1, 0, 0, 0);
        cyc();
        expect_idle("rst_idle", 0, 0, 0);
        cyc(); rst = 1'b0; ED_mode = 2'b00;
        expect_idle("rst_rel", 0, 0, 0);
        cyc(); data_feedback = 1'b1;
        expect_idle("pend_rst", 0, 1, 1);
        cyc(); data_feedback = 1'b0; ED_start = 1'b0;
        cyc(); cyc();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge tb_clk);
        check("drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_helper_mux.md
Name: ahb_helper_mux

Overview:
- Request multiplexer and response router between two client engines and a single AHB master interface.
- Clients: RC4 decryption engine and Edge-Detection engine. Edge-Detection has two sub-ports: Sample-Image read (SI) and ED result write.
- The block grants the master to one engine, drives that engine's request (mode, pixNum, wdata, size, startAddr_sel), and routes rdata/data_feedback back to the requester.

Parameters:
- ADDR_W, 20, pixel-number width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- RC4_start  in  1  RC4 engine requests bus ownership (level)
- ED_start  in  1  Edge-Detection engine requests bus ownership (level)
- RC4_wdata  in  32  RC4 write data
- RC4_pixNum  in  20  RC4 pixel/word index
- RC4_mode  in  2  RC4 request: 00 none, 01 read, 10 write, 11 treated as none
- ED_wdata  in  32  ED result write data
- ED_wpixNum  in  20  ED write pixel index
- ED_mode  in  2  ED write request (same encoding)
- SI_rpixNum  in  20  sample-image read pixel index
- SI_mode  in  2  sample-image read request (same encoding)
- rdata  in  32  read data from AHB master
- data_feedback  in  1  one-cycle pulse from master: transfer complete
- RC4_rdata  out  32  read data to RC4
- RC4_dfb  out  1  completion to RC4
- ED_dfb  out  1  completion to Edge-Detection
- SI_rdata  out  32  read data to sample-image storage
- SI_dfb  out  1  completion to sample-image storage
- startAddr_sel  out  1  0 = source-image base region, 1 = destination base region
- wdata  out  32  write data to master
- size  out  2  transfer size to master
- mode  out  2  request to master
- pixNum  out  20  pixel index to master

Behaviour:
- Owner FSM, registered, states IDLE, RC4, ED. Reset to IDLE; pending_src register resets to SI.
- IDLE -> RC4 when RC4_start=1. RC4 wins if both start inputs are high.
- IDLE -> ED when ED_start=1 and RC4_start=0.
- RC4 -> IDLE when RC4_start=0. ED -> IDLE when ED_start=0. No direct RC4<->ED transition.
- The transition takes effect at the clock edge; outputs follow the new state in the same cycle (combinational decode of state and inputs).
- IDLE outputs: mode=00, size=00, pixNum=0, wdata=0, startAddr_sel=0. All dfb outputs 0.
- RC4 state: mode=RC4_mode, pixNum=RC4_pixNum, wdata=RC4_wdata. startAddr_sel=1 when RC4_mode=10, else 0.
- ED state, SI_mode != 00 (SI has priority): mode=SI_mode, pixNum=SI_rpixNum, wdata=0, startAddr_sel=0.
- ED state, SI_mode=00 and ED_mode != 00: mode=ED_mode, pixNum=ED_wpixNum, wdata=ED_wdata, startAddr_sel=1.
- ED state, both modes 00: outputs as in IDLE.
- size=2'b10 (32-bit word) whenever the driven mode is 01 or 10; otherwise 00. Mode 11 is forwarded as 00.
- pending_src: in ED state, updated each clock where a request is driven (SI or ED). Holds its value when the request drops to 00, so feedback arriving later is routed correctly.
- RC4_rdata = rdata and SI_rdata = rdata always (combinational pass-through, no gating).
- RC4_dfb = data_feedback & (state==RC4).
- ED_dfb = data_feedback & (state==ED).
- SI_dfb = data_feedback & (state==ED) & (pending_src==SI).
- data_feedback in IDLE is ignored.
- Reset mid-transfer: state returns to IDLE at that edge; outputs go to IDLE values immediately.
- Owner drop (start low) with a request outstanding: bus is released anyway; the client is responsible for holding start until its feedback arrives.

Test Plan:
- Idle after reset, all request inputs 0 for 2 cycles -> mode=00, size=00, pixNum=0, wdata=0, all dfb=0.
- ED_start=1, ED_mode=01, SI_mode=01, SI_rpixNum=1 -> pixNum=1, mode=01, size=10, startAddr_sel=0.
- SI_mode back to 00; rdata=1, data_feedback pulsed 1 cycle -> SI_rdata=1; ED_dfb=1 and SI_dfb=1 during the pulse, 0 after.
- Buffer fill: SI reads at pixNum 481 then 961 with rdata 255 then 512 -> pixNum matches each request; SI_rdata tracks rdata; ED_dfb tracks data_feedback.
- ED write: SI_mode=00, ED_mode=10, ED_wpixNum=5, ED_wdata=0xA5 -> mode=10, pixNum=5, wdata=0xA5, startAddr_sel=1, size=10. Feedback raises ED_dfb only; SI_dfb=0.
- Arbitration: RC4_start and ED_start both set in IDLE -> RC4 owns, mode=RC4_mode. After RC4_start drops -> IDLE, then ED owns next cycle. Reset asserted mid-ED -> IDLE outputs immediately.
